// File: rtl/m2v_side_pkg.sv
// Shared definitions for the stage-4 side-information queue.
// Record layout, MSB first: {mb_x, mb_y, mb_intra, block, coded}.
package m2v_side_pkg;

    localparam int MBX_W     = 6;
    localparam int MBY_W     = 5;
    localparam int BLOCK_W   = 3;
    localparam int BLOCK_MAX = 5;
    localparam int SIDE_W    = MBX_W + MBY_W + 5;

    function automatic int side_w(input int mbx, input int mby);
        return mbx + mby + BLOCK_W + 2;
    endfunction

endpackage

// File: rtl/m2vside_queue_mem.sv
// Side-information storage array for m2vside_queue.
// One write port, asynchronous read, contents not reset.
module m2vside_queue_mem #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2,
    parameter int W         = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the pushed record into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/m2vside_queue.sv
// Stage-4 side-information FIFO between s3 and m2vmc.
// Push via valid/ready, pop on block_start into registered outputs.
module m2vside_queue
    import m2v_side_pkg::*;
#(
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [MBX_WIDTH-1:0] in_mb_x,
    input  logic [MBY_WIDTH-1:0] in_mb_y,
    input  logic                 in_mb_intra,
    input  logic [2:0]           in_block,
    input  logic                 in_coded,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 block_start,
    output logic [MBX_WIDTH-1:0] out_mb_x,
    output logic [MBY_WIDTH-1:0] out_mb_y,
    output logic                 out_mb_intra,
    output logic [2:0]           out_block,
    output logic                 out_coded,
    output logic                 out_enable,
    output logic [PTR_WIDTH:0]   level,
    output logic                 empty,
    output logic                 full,
    output logic                 underrun
);

    localparam int SW = side_w(MBX_WIDTH, MBY_WIDTH);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [SW-1:0]        wr_data;
    logic [SW-1:0]        rd_data;
    logic                 push;
    logic                 pop;

    assign empty    = (level == '0);
    assign full     = (level == (PTR_WIDTH+1)'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = block_start & ~empty;
    assign wr_data  = {in_mb_x, in_mb_y, in_mb_intra, in_block, in_coded};

    m2vside_queue_mem #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .W         (SW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + (PTR_WIDTH+1)'(1);
                2'b01:   level <= level - (PTR_WIDTH+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Output stage: load on pop, flag underrun on an empty pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_mb_x     <= '0;
            out_mb_y     <= '0;
            out_mb_intra <= 1'b0;
            out_block    <= '0;
            out_coded    <= 1'b0;
            out_enable   <= 1'b0;
            underrun     <= 1'b0;
        end else if (flush) begin
            out_enable <= 1'b0;
            underrun   <= 1'b0;
        end else if (pop) begin
            out_mb_x     <= rd_data[SW-1 -: MBX_WIDTH];
            out_mb_y     <= rd_data[SW-MBX_WIDTH-1 -: MBY_WIDTH];
            out_mb_intra <= rd_data[4];
            out_block    <= rd_data[3:1];
            out_coded    <= rd_data[0];
            out_enable   <= 1'b1;
        end else if (block_start) begin
            out_enable <= 1'b0;
            underrun   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_m2vside_queue.sv
// Directed testbench for m2vside_queue.
// One task per scenario, inline comparisons.
module tb_m2vside_queue;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] in_mb_x = '0;
    logic [4:0] in_mb_y = '0;
    logic       in_mb_intra = 1'b0;
    logic [2:0] in_block = '0;
    logic       in_coded = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       block_start = 1'b0;
    logic [5:0] out_mb_x;
    logic [4:0] out_mb_y;
    logic       out_mb_intra;
    logic [2:0] out_block;
    logic       out_coded;
    logic       out_enable;
    logic [2:0] level;
    logic       empty;
    logic       full;
    logic       underrun;

    int pass_cnt = 0;
    int total = 0;

    m2vside_queue dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_mb_x      (in_mb_x),
        .in_mb_y      (in_mb_y),
        .in_mb_intra  (in_mb_intra),
        .in_block     (in_block),
        .in_coded     (in_coded),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .block_start  (block_start),
        .out_mb_x     (out_mb_x),
        .out_mb_y     (out_mb_y),
        .out_mb_intra (out_mb_intra),
        .out_block    (out_block),
        .out_coded    (out_coded),
        .out_enable   (out_enable),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input int x, input int y, input int blk);
        in_mb_x     = 6'(x);
        in_mb_y     = 5'(y);
        in_mb_intra = 1'(x);
        in_block    = 3'(blk);
        in_coded    = 1'(blk);
    endtask

    task automatic push_one(input int x, input int y, input int blk);
        set_rec(x, y, blk);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        block_start = 1'b1;
        step();
        block_start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        total++;
        if ({level, empty, full, in_ready, out_enable, underrun}
            !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: lvl=%0d e=%b f=%b rdy=%b oe=%b ur=%b, want 0 1 0 1 0 0",
                     level, empty, full, in_ready, out_enable, underrun);
        else pass_cnt++;
        total++;
        if ({out_mb_x, out_mb_y, out_block} !== 14'd0)
            $display("FAIL reset_outs: x=%0d y=%0d blk=%0d, want 0", out_mb_x, out_mb_y, out_block);
        else pass_cnt++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_rec(3, 2, 4);
        in_mb_intra = 1'b1;
        in_coded = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (level !== 3'd1) $display("FAIL single_lvl1: got %0d want 1", level);
        else pass_cnt++;
        step();
        pop_one();
        total++;
        if ({out_mb_x, out_mb_y, out_mb_intra, out_block, out_coded, out_enable}
            !== {6'd3, 5'd2, 1'b1, 3'd4, 1'b1, 1'b1})
            $display("FAIL single_out: x=%0d y=%0d i=%b b=%0d c=%b oe=%b want 3 2 1 4 1 1",
                     out_mb_x, out_mb_y, out_mb_intra, out_block, out_coded, out_enable);
        else pass_cnt++;
        total++;
        if (level !== 3'd0) $display("FAIL single_lvl0: got %0d want 0", level);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push_one(i + 8, i, i);
        total++;
        if ({full, in_ready, level} !== {1'b1, 1'b0, 3'd4})
            $display("FAIL fill_full: f=%b rdy=%b lvl=%0d want 1 0 4", full, in_ready, level);
        else pass_cnt++;
        push_one(40, 9, 5);
        total++;
        if (level !== 3'd4) $display("FAIL fill_reject: lvl=%0d want 4", level);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            pop_one();
            total++;
            if ({out_block, out_mb_x} !== {3'(i), 6'(i + 8)})
                $display("FAIL fill_pop%0d: blk=%0d x=%0d want %0d %0d", i, out_block, out_mb_x, i, i + 8);
            else pass_cnt++;
        end
        total++;
        if (empty !== 1'b1) $display("FAIL fill_empty: got %b want 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_underrun();
        pop_one();
        total++;
        if ({out_enable, underrun, out_block} !== {1'b0, 1'b1, 3'd3})
            $display("FAIL ur_set: oe=%b ur=%b blk=%0d want 0 1 3", out_enable, underrun, out_block);
        else pass_cnt++;
        push_one(1, 1, 2);
        pop_one();
        total++;
        if ({out_enable, underrun, out_block} !== {1'b1, 1'b1, 3'd2})
            $display("FAIL ur_sticky: oe=%b ur=%b blk=%0d want 1 1 2", out_enable, underrun, out_block);
        else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if ({out_enable, underrun} !== 2'b00)
            $display("FAIL ur_flush: oe=%b ur=%b want 0 0", out_enable, underrun);
        else pass_cnt++;
    endtask

    task automatic test_simul();
        push_one(10, 1, 1);
        push_one(11, 2, 2);
        set_rec(12, 3, 3);
        in_valid = 1'b1;
        block_start = 1'b1;
        step();
        in_valid = 1'b0;
        block_start = 1'b0;
        total++;
        if ({level, out_block, out_mb_x} !== {3'd2, 3'd1, 6'd10})
            $display("FAIL simul_mid: lvl=%0d blk=%0d x=%0d want 2 1 10", level, out_block, out_mb_x);
        else pass_cnt++;
        push_one(13, 4, 4);
        push_one(14, 5, 5);
        set_rec(15, 6, 0);
        in_valid = 1'b1;
        block_start = 1'b1;
        step();
        in_valid = 1'b0;
        block_start = 1'b0;
        total++;
        if ({level, out_block, in_ready} !== {3'd3, 3'd2, 1'b1})
            $display("FAIL simul_full: lvl=%0d blk=%0d rdy=%b want 3 2 1", level, out_block, in_ready);
        else pass_cnt++;
        for (int i = 3; i < 6; i++) begin
            pop_one();
            total++;
            if (out_block !== 3'(i))
                $display("FAIL simul_drain%0d: blk=%0d want %0d", i, out_block, i);
            else pass_cnt++;
        end
        total++;
        if (empty !== 1'b1) $display("FAIL simul_empty: got %b want 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) push_one(20 + i, i, i);
        pop_one();
        flush = 1'b1;
        set_rec(30, 7, 5);
        in_valid = 1'b1;
        block_start = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        block_start = 1'b0;
        total++;
        if ({level, empty, out_enable, out_mb_x} !== {3'd0, 1'b1, 1'b0, 6'd20})
            $display("FAIL flush_all: lvl=%0d e=%b oe=%b x=%0d want 0 1 0 20",
                     level, empty, out_enable, out_mb_x);
        else pass_cnt++;
        push_one(33, 1, 1);
        pop_one();
        total++;
        if (out_mb_x !== 6'd33) $display("FAIL flush_after: x=%0d want 33", out_mb_x);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push_one(40 + i, i, i);
        pop_one();
        total++;
        if ({level, out_enable} !== {3'd2, 1'b1})
            $display("FAIL arst_pre: lvl=%0d oe=%b want 2 1", level, out_enable);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({out_enable, level, in_ready, out_mb_x} !== {1'b0, 3'd0, 1'b1, 6'd0})
            $display("FAIL arst_clear: oe=%b lvl=%0d rdy=%b x=%0d want 0 0 1 0",
                     out_enable, level, in_ready, out_mb_x);
        else pass_cnt++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        set_rec(0, 0, 0);
        in_valid = 1'b1;
        step();
        for (int i = 1; i < 10; i++) begin
            set_rec(i, i, i % 6);
            in_valid = 1'b1;
            block_start = 1'b1;
            step();
            total++;
            if ({out_mb_x, out_mb_y, out_block, level} !== {6'(i - 1), 5'(i - 1), 3'((i - 1) % 6), 3'd1})
                $display("FAIL wrap_%0d: x=%0d y=%0d blk=%0d lvl=%0d want %0d %0d %0d 1",
                         i, out_mb_x, out_mb_y, out_block, level, i - 1, i - 1, (i - 1) % 6);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        pop_one();
        total++;
        if ({out_mb_x, out_block, empty} !== {6'd9, 3'd3, 1'b1})
            $display("FAIL wrap_last: x=%0d blk=%0d e=%b want 9 3 1", out_mb_x, out_block, empty);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_underrun();
        test_simul();
        test_flush();
        test_async_reset();
        do_reset();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
